conv_phase_sequencer: RTL and testbench

Drives the `state_end` input of the ConvUnit phase state machine (INIT→A→B→C→A…) and tracks its `current_state`. The block times each phase by counting per-phase beats, pulses `state_end` when a phase's work is complete, and waits for the state machine to acknowledge the transition before timing the next phase. After a programmed number of A/B/C rounds it stops in C and reports `done`, so the convolution datapath and the state machine stay lock-stepped.

---
 rtl/conv_phase_sequencer.sv | 167 ++++++++++++++++
 tb/tb_conv_phase_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_phase_sequencer.sv
// Phase timer for the ConvUnit INIT/A/B/C state machine: counts beats per phase, pulses state_end, waits for ack.
// Optional macro PHASE_TIMEOUT_EN adds a sticky ack-wait timeout (timeout_err) after TIMEOUT cycles.
module conv_phase_sequencer #(
    parameter int unsigned A_LEN      = 16,
    parameter int unsigned B_LEN      = 64,
    parameter int unsigned C_LEN      = 16,
    parameter int unsigned NUM_ROUNDS = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RND_W      = 8
`ifdef PHASE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic [2:0]       current_state,
    output logic             state_end,
    output logic             phase_active,
    output logic [CNT_W-1:0] beat_idx,
    output logic [RND_W-1:0] round_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam logic [2:0] PH_INIT = 3'd0;
    localparam logic [2:0] PH_A    = 3'd1;
    localparam logic [2:0] PH_B    = 3'd2;
    localparam logic [2:0] PH_C    = 3'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_SW = 2'd1,
        COUNT   = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       old_ph;
    logic [2:0]       cur_ph;
    logic [CNT_W-1:0] last_beat;
    logic             ph_valid;
    logic             final_round;

    // Last beat index of the phase currently being timed
    always_comb begin
        last_beat = CNT_W'(C_LEN - 1);
        case (cur_ph)
            PH_A:    last_beat = CNT_W'(A_LEN - 1);
            PH_B:    last_beat = CNT_W'(B_LEN - 1);
            default: last_beat = CNT_W'(C_LEN - 1);
        endcase
    end

    assign ph_valid    = (current_state == PH_A) || (current_state == PH_B) || (current_state == PH_C);
    assign final_round = (round_idx == RND_W'(NUM_ROUNDS - 1));

`ifdef PHASE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            old_ph       <= PH_INIT;
            cur_ph       <= PH_INIT;
            state_end    <= 1'b0;
            phase_active <= 1'b0;
            beat_idx     <= '0;
            round_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            state_end <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse belongs to the finished run
                    if (start && !done && (current_state == PH_INIT || current_state == PH_C)) begin
                        round_idx <= '0;
                        state_end <= 1'b1;
                        old_ph    <= current_state;
                        busy      <= 1'b1;
                        state     <= WAIT_SW;
`ifdef PHASE_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end

                WAIT_SW: begin
                    if (current_state != old_ph) begin
                        if (ph_valid) begin
                            cur_ph       <= current_state;
                            beat_idx     <= '0;
                            phase_active <= 1'b1;
                            state        <= COUNT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
`ifdef PHASE_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end

                COUNT: begin
                    if (!ph_valid) begin
                        phase_active <= 1'b0;
                        beat_idx     <= '0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (current_state != cur_ph) begin
                        // Unrequested phase change: time the new phase from scratch
                        cur_ph   <= current_state;
                        beat_idx <= '0;
                    end else if (!stall) begin
                        if (beat_idx == last_beat) begin
                            phase_active <= 1'b0;
                            beat_idx     <= '0;
                            if (cur_ph == PH_C && final_round) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state_end <= 1'b1;
                                old_ph    <= cur_ph;
                                state     <= WAIT_SW;
`ifdef PHASE_TIMEOUT_EN
                                wait_cnt  <= '0;
`endif
                                if (cur_ph == PH_C) begin
                                    round_idx <= round_idx + RND_W'(1);
                                end
                            end
                        end else begin
                            beat_idx <= beat_idx + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    phase_active <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_phase_sequencer.sv
// Bench for conv_phase_sequencer: a small ConvUnit state-machine model plus a state_end/done event scoreboard.
module tb_conv_phase_sequencer;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned RND_W = 8;
    localparam int EV_SE   = 0;
    localparam int EV_DONE = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stall;
    logic [2:0]       current_state;
    logic             state_end;
    logic             phase_active;
    logic [CNT_W-1:0] beat_idx;
    logic [RND_W-1:0] round_idx;
    logic             busy;
    logic             done;
    logic             timeout_err;

    logic [2:0] sm;
    logic       hold;
    logic       ovr_en;
    logic [2:0] ovr_val;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int b;

    typedef struct {
        int kind;
        int at;
    } ev_t;
    ev_t exp_q[$];

    conv_phase_sequencer #(
        .A_LEN(4), .B_LEN(8), .C_LEN(2), .NUM_ROUNDS(2), .CNT_W(CNT_W), .RND_W(RND_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .current_state(current_state),
        .state_end(state_end), .phase_active(phase_active), .beat_idx(beat_idx),
        .round_idx(round_idx), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ConvUnit state machine: INIT->A->B->C->A on each state_end
    always @(posedge clk) begin
        if (rst) sm <= 3'd0;
        else if (state_end && !hold) sm <= (sm == 3'd3) ? 3'd1 : sm + 3'd1;
    end

    assign current_state = ovr_en ? ovr_val : sm;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic pop_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.at);
        end
    endtask

    // Monitor: every state_end/done pulse must match the next expected event
    always @(negedge clk) begin
        if (state_end) pop_ev(EV_SE);
        if (done) pop_ev(EV_DONE);
    end

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state_end"}, int'(state_end), 0);
        chk({tag, "_phase_active"}, int'(phase_active), 0);
        chk({tag, "_beat_idx"}, int'(beat_idx), 0);
        chk({tag, "_round_idx"}, int'(round_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; hold = 1'b0; ovr_en = 1'b0; ovr_val = 3'd0;
        repeat (3) step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Full run from INIT: A=4, B=8, C=2, two rounds
        b = cyc;
        push(EV_SE, b + 1);  push(EV_SE, b + 7);  push(EV_SE, b + 17);
        push(EV_SE, b + 21); push(EV_SE, b + 27); push(EV_SE, b + 37);
        push(EV_DONE, b + 41);
        pulse_start();
        chk("run_busy_waitsw", int'(busy), 1);
        chk("run_phase_active_waitsw", int'(phase_active), 0);
        step_to(b + 4);
        chk("run_beat_a1", int'(beat_idx), 1);
        chk("run_phase_active", int'(phase_active), 1);
        step_to(b + 23);
        chk("run_round2", int'(round_idx), 1);
        chk("run_round2_beat0", int'(beat_idx), 0);
        step_to(b + 41);
        chk("run_done_busy", int'(busy), 0);
        chk("run_done_state", int'(current_state), 3);
        // start together with done must be ignored
        pulse_start();
        repeat (4) step();
        chk("start_at_done_busy", int'(busy), 0);
        chk("start_at_done_state", int'(current_state), 3);

        // Restart from C, stall 3 cycles on beat 3 of A, then reset mid-B
        b = cyc;
        push(EV_SE, b + 1); push(EV_SE, b + 10);
        pulse_start();
        step_to(b + 2);
        chk("restart_state_a", int'(current_state), 1);
        chk("restart_round0", int'(round_idx), 0);
        step_to(b + 6);
        chk("stall_beat_c6", int'(beat_idx), 3);
        stall = 1'b1;
        step();
        chk("stall_beat_c7", int'(beat_idx), 3);
        step();
        chk("stall_beat_c8", int'(beat_idx), 3);
        step();
        chk("stall_beat_c9", int'(beat_idx), 3);
        chk("stall_no_state_end", int'(state_end), 0);
        stall = 1'b0;
        step_to(b + 14);
        chk("mid_b_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        chk_idle_outputs("mid_reset");
        step();
        rst = 1'b0;
        step();

        // Invalid state during COUNT aborts without done; start while in B is ignored
        b = cyc;
        push(EV_SE, b + 1); push(EV_SE, b + 7);
        pulse_start();
        step_to(b + 12);
        chk("pre_invalid_state_b", int'(current_state), 2);
        ovr_en = 1'b1; ovr_val = 3'd5;
        step();
        chk("invalid_busy", int'(busy), 0);
        chk("invalid_phase_active", int'(phase_active), 0);
        chk("invalid_done", int'(done), 0);
        ovr_en = 1'b0;
        pulse_start();
        repeat (4) step();
        chk("start_in_b_busy", int'(busy), 0);
        chk("start_in_b_state", int'(current_state), 2);

`ifdef PHASE_TIMEOUT_EN
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        hold = 1'b1;
        step();
        b = cyc;
        push(EV_SE, b + 1);
        pulse_start();
        step_to(b + 8);
        chk("timeout_before", int'(timeout_err), 0);
        step();
        chk("timeout_set", int'(timeout_err), 1);
        chk("timeout_busy", int'(busy), 0);
        repeat (5) step();
        chk("timeout_sticky", int'(timeout_err), 1);
        rst = 1'b1;
        step();
        chk("timeout_cleared", int'(timeout_err), 0);
        rst = 1'b0;
        hold = 1'b0;
`endif

        repeat (2) step();
        chk("pending_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
